stopwatch_lap_timer: RTL

Parametrised successor to the basic stopwatch: a minutes:seconds timer with a built-in one-second prescaler, up/down counting mode, preset load, lap capture and a countdown-complete state. It sits directly under the board top, driven by debounced, single-cycle button pulses, and feeds the display and LED logic. Seconds and minutes live in one block, so the up and down carry and borrow paths are a single coherent counter.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 38 +++
 rtl/stopwatch_lap_timer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/lap timer: state encoding and the
// seconds field geometry.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int              SEC_W   = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by TICK_DIV while enabled; tick is high on the enabled cycle
// in which the counter sits on its last value.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Holding while disabled is what lets a discarded tick fire on resume.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Minutes:seconds stopwatch with up/down counting, preset load, lap capture
// and countdown-complete state; all outputs registered.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MIN_W    = 8,
  parameter int MAX_MIN  = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             reset,
  input  logic             lap,
  input  logic             mode_down,
  input  logic             load_en,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] lap_minutes,
  output logic [SEC_W-1:0] lap_seconds,
  output logic             lap_valid,
  output logic [1:0]       status,
  output logic             done,
  output logic             wrap
);

  localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MAX_MIN);

  state_e           state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             mode_q, mode_d;
  logic [MIN_W-1:0] lap_min_q, lap_min_d;
  logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
  logic             lap_valid_q, lap_valid_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic tick;
  logic time_zero;
  logic load_ok;
  logic presc_en;
  logic presc_clr;

  assign time_zero = (min_q == '0) && (sec_q == '0);
  // Load is the lowest-priority command, so any higher button masks it.
  assign load_ok   = !reset && !stop && !start && load_en &&
                     ((state_q == S_IDLE) || (state_q == S_PAUSE));
  assign presc_en  = (state_q == S_RUN) && !reset && !stop;
  assign presc_clr = reset || load_ok;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    mode_d      = mode_q;
    lap_min_d   = lap_min_q;
    lap_sec_d   = lap_sec_q;
    lap_valid_d = lap_valid_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;

    if (reset) begin
      state_d     = S_IDLE;
      min_d       = '0;
      sec_d       = '0;
      mode_d      = 1'b0;
      lap_min_d   = '0;
      lap_sec_d   = '0;
      lap_valid_d = 1'b0;
    end else begin
      if (lap && (state_q == S_RUN)) begin
        lap_min_d   = min_q;
        lap_sec_d   = sec_q;
        lap_valid_d = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          // A countdown from 00:00 would finish instantly, so refuse it.
          if (!stop && start && !(mode_down && time_zero)) begin
            state_d = S_RUN;
            mode_d  = mode_down;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            if (!mode_q) begin
              if (sec_q == SEC_MAX) begin
                sec_d = '0;
                if (min_q == MIN_MAX) begin
                  min_d  = '0;
                  wrap_d = 1'b1;
                end else begin
                  min_d = min_q + 1'b1;
                end
              end else begin
                sec_d = sec_q + 1'b1;
              end
            end else begin
              if (time_zero || ((min_q == '0) && (sec_q == SEC_W'(1)))) begin
                min_d   = '0;
                sec_d   = '0;
                state_d = S_DONE;
                done_d  = 1'b1;
              end else if (sec_q == '0) begin
                sec_d = SEC_MAX;
                min_d = min_q - 1'b1;
              end else begin
                sec_d = sec_q - 1'b1;
              end
            end
          end
        end
        S_PAUSE: begin
          if (!stop && start) begin
            state_d = S_RUN;
          end
        end
        default: begin
        end
      endcase

      if (load_ok) begin
        sec_d = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
        min_d = (load_min > MIN_MAX) ? MIN_MAX : load_min;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      min_q       <= '0;
      sec_q       <= '0;
      mode_q      <= 1'b0;
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
      lap_valid_q <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      mode_q      <= mode_d;
      lap_min_q   <= lap_min_d;
      lap_sec_q   <= lap_sec_d;
      lap_valid_q <= lap_valid_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
    end
  end

  assign minutes     = min_q;
  assign seconds     = sec_q;
  assign lap_minutes = lap_min_q;
  assign lap_seconds = lap_sec_q;
  assign lap_valid   = lap_valid_q;
  assign status      = state_q;
  assign done        = done_q;
  assign wrap        = wrap_q;

endmodule
